// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: shares the memory bus between the CPU and a 160-byte
// copy from {dma_reg,8'h00} into OAM, fencing the CPU to HRAM meanwhile.
module oam_dma_arbiter #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] DEST_BASE    = 16'hFE00,
   parameter int unsigned LENGTH       = 160,
   parameter logic [15:0] HRAM_LO      = 16'hFF80,
   parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active,
   output logic        dma_done
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      RD,
      WR
   } state_t;

   localparam logic [7:0] LAST = 8'(LENGTH - 1);

   state_t     state, state_nxt;
   logic [7:0] dma_reg, dma_reg_nxt;
   logic [7:0] idx, idx_nxt;
   logic [7:0] byte_buf, byte_buf_nxt;
   logic       done_nxt;

   logic reg_hit, reg_wr, active, hram;
   logic cpu_wins, dma_go;

   assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
   assign reg_wr   = reg_hit && cpu_we;
   assign active   = (state != IDLE);
   assign hram     = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
   assign cpu_wins = active && hram && !reg_hit && (cpu_re || cpu_we);
   assign dma_go   = ((state == RD) || (state == WR)) && !cpu_wins && !reg_wr;

   assign dma_active = active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         dma_reg  <= 8'h00;
         idx      <= 8'h00;
         byte_buf <= 8'h00;
         dma_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         dma_reg  <= dma_reg_nxt;
         idx      <= idx_nxt;
         byte_buf <= byte_buf_nxt;
         dma_done <= done_nxt;
      end
   end

   // A register write restarts the copy from any state, aborting the byte.
   always_comb begin
      state_nxt    = state;
      dma_reg_nxt  = dma_reg;
      idx_nxt      = idx;
      byte_buf_nxt = byte_buf;
      done_nxt     = 1'b0;
      if (reg_wr) begin
         dma_reg_nxt = cpu_wdata;
         idx_nxt     = 8'h00;
         state_nxt   = START;
      end else if (active && !cpu_wins) begin
         case (state)
            START: state_nxt = RD;
            RD: begin
               byte_buf_nxt = mem_rdata;
               state_nxt    = WR;
            end
            WR: begin
               if (idx == LAST) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt   = idx + 8'd1;
                  state_nxt = RD;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_addr  = cpu_addr;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
      if (reg_hit) begin
         cpu_rdata = dma_reg;
      end else if (!active || hram) begin
         mem_re = cpu_re;
         mem_we = cpu_we;
      end else begin
         cpu_rdata = 8'hFF;
      end
      if (dma_go) begin
         if (state == RD) begin
            mem_addr = {dma_reg, idx};
            mem_re   = 1'b1;
         end else begin
            mem_addr  = DEST_BASE + {8'h00, idx};
            mem_we    = 1'b1;
            mem_wdata = byte_buf;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter against a step-count bus model
// and a 64 KiB memory image.
module tb_oam_dma_arbiter;

   localparam int LEN = 160;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_re;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        dma_active;
   logic        dma_done;

   logic [7:0] mem [0:65535];

   int n_chk;
   int n_fail;
   int act_cnt;
   int done_cnt;
   int win_cnt;

   // model: -1 idle, 0 start cycle, odd = read byte, even = write byte
   int         m_step;
   logic [7:0] m_reg;
   logic       m_done;

   oam_dma_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_re    (cpu_re),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .dma_active(dma_active),
      .dma_done  (dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_cyc(input logic [15:0] a,
                         input logic r,
                         input logic w,
                         input logic [7:0] d);
      logic        hit, hr, act, wins, go;
      logic [15:0] e_addr;
      logic        e_re, e_we;
      logic [7:0]  e_wd, e_rd;
      int          b;
      cpu_addr  = a;
      cpu_re    = r;
      cpu_we    = w;
      cpu_wdata = d;
      #3;
      hit  = (a == 16'hFF46);
      hr   = (a >= 16'hFF80) && (a <= 16'hFFFE);
      act  = (m_step >= 0);
      wins = act && hr && (r || w);
      go   = act && (m_step > 0) && !wins && !(hit && w);
      e_addr = a;
      e_re   = 1'b0;
      e_we   = 1'b0;
      e_wd   = d;
      if (hit) begin
         e_rd = m_reg;
      end else if (!act || hr) begin
         e_re = r;
         e_we = w;
         e_rd = mem[a];
      end else begin
         e_rd = 8'hFF;
      end
      if (go) begin
         if (m_step % 2 == 1) begin
            b      = (m_step - 1) / 2;
            e_addr = {m_reg, 8'(b)};
            e_re   = 1'b1;
         end else begin
            b      = m_step / 2 - 1;
            e_addr = 16'hFE00 + 16'(b);
            e_we   = 1'b1;
            e_wd   = mem[{m_reg, 8'(b)}];
         end
      end
      check("dma_active", 16'(dma_active), 16'(act));
      check("dma_done", 16'(dma_done), 16'(m_done));
      check("mem_re", 16'(mem_re), 16'(e_re));
      check("mem_we", 16'(mem_we), 16'(e_we));
      check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", 16'(mem_wdata), 16'(e_wd));
      if (r) check("cpu_rdata", 16'(cpu_rdata), 16'(e_rd));
      if (dma_active) act_cnt++;
      if (dma_done) done_cnt++;
      if (wins) win_cnt++;
      @(posedge clk);
      m_done = 1'b0;
      if (hit && w) begin
         m_reg  = d;
         m_step = 0;
      end else if (act && !wins) begin
         if (m_step == 2 * LEN) begin
            m_step = -1;
            m_done = 1'b1;
         end else begin
            m_step++;
         end
      end
      #1;
   endtask

   task automatic rnd_cyc(input bit hram_ok);
      logic [15:0] a;
      int          k;
      a = 16'($urandom);
      if (hram_ok && $urandom_range(0, 3) == 0)
         a = 16'hFF80 + 16'($urandom_range(0, 126));
      else if ((a >= 16'hFF80 && a <= 16'hFFFE) || a == 16'hFF46)
         a = 16'hC000;
      k = $urandom_range(0, 2);
      do_cyc(a, k == 1, k == 2, 8'($urandom));
   endtask

   task automatic start(input logic [7:0] src);
      do_cyc(16'hFF46, 1'b0, 1'b1, src);
      act_cnt  = 0;
      done_cnt = 0;
      win_cnt  = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         do_cyc(16'($urandom), 1'b0, 1'b0, 8'h00);
   endtask

   // mode 0: idle bus, 1: non-HRAM traffic, 2: traffic incl. HRAM
   task automatic drain(input int mode);
      int n;
      n = 0;
      while ((m_step >= 0 || m_done) && n < 2000) begin
         if (mode == 0) idle_cycles(1);
         else rnd_cyc(mode == 2);
         n++;
      end
      if (n >= 2000) check("drain_timeout", 16'd1, 16'd0);
   endtask

   task automatic oam_cmp(input logic [7:0] src, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++)
         if (mem[16'hFE00 + 16'(i)] !== mem[{src, 8'(i)}]) bad++;
      check("oam_data", 16'(bad), 16'd0);
   endtask

   initial begin
      logic [7:0] src;
      n_chk     = 0;
      n_fail    = 0;
      act_cnt   = 0;
      done_cnt  = 0;
      win_cnt   = 0;
      m_step    = -1;
      m_reg     = 8'h00;
      m_done    = 1'b0;
      rst       = 1'b1;
      cpu_addr  = 16'h0000;
      cpu_re    = 1'b0;
      cpu_we    = 1'b0;
      cpu_wdata = 8'h00;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_active", 16'(dma_active), 16'd0);
      check("rst_done", 16'(dma_done), 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_cyc(16'hFF46, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++) rnd_cyc(1'b1);

      start(8'hC1);
      drain(0);
      check("len_c1", 16'(act_cnt), 16'd321);
      check("done_c1", 16'(done_cnt), 16'd1);
      do_cyc(16'hFF46, 1'b1, 1'b0, 8'h00);
      oam_cmp(8'hC1, LEN);

      src = 8'($urandom_range(8'h80, 8'hDF));
      start(src);
      do_cyc(16'hC000, 1'b1, 1'b0, 8'h00);
      do_cyc(16'hC000, 1'b0, 1'b1, 8'h77);
      drain(1);
      check("len_blocked", 16'(act_cnt), 16'd321);
      check("done_blocked", 16'(done_cnt), 16'd1);
      oam_cmp(src, LEN);

      start(8'hC1);
      idle_cycles(11);
      do_cyc(16'hFF80, 1'b0, 1'b1, 8'h5A);
      drain(0);
      check("len_hram", 16'(act_cnt), 16'd322);
      check("hram_byte", 16'(mem[16'hFF80]), 16'h005A);
      oam_cmp(8'hC1, LEN);

      src = 8'($urandom_range(8'h80, 8'hDF));
      start(src);
      drain(2);
      check("len_mixed", 16'(act_cnt), 16'(321 + win_cnt));
      oam_cmp(src, LEN);

      start(8'hC1);
      idle_cycles(101);
      start(8'hD0);
      drain(0);
      check("len_restart", 16'(act_cnt), 16'd321);
      check("done_restart", 16'(done_cnt), 16'd1);
      oam_cmp(8'hD0, LEN);

      src = 8'($urandom_range(8'h80, 8'hDF));
      start(src);
      idle_cycles(161);
      rst = 1'b1;
      #1;
      check("async_active", 16'(dma_active), 16'd0);
      check("async_done", 16'(dma_done), 16'd0);
      m_step = -1;
      m_reg  = 8'h00;
      m_done = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycles(5);
      do_cyc(16'hFF46, 1'b1, 1'b0, 8'h00);
      check("done_after_rst", 16'(done_cnt), 16'd0);
      oam_cmp(src, 80);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
